// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared constants, the pipeline stage record and compare helpers for hazard_ctrl.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  localparam int AW = 5;  // register address width
  localparam int TW = 3;  // Tuse/Tnew width

  // Tuse value meaning "this operand is not read"
  localparam logic [TW-1:0] TUSE_NONE = 3'd7;

  // Forwarding mux encodings
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] waddr;
    logic [TW-1:0] tnew;
  } stage_rec_t;

  // Tnew counts down one per stage and sticks at zero once the result exists
  function automatic logic [TW-1:0] tnew_age(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Producer x's result will not exist by the time the consumer needs it
  function automatic logic stall_hit(input stage_rec_t x,
                                     input logic [AW-1:0] raddr,
                                     input logic [TW-1:0] tuse);
    return (x.waddr != '0) && (x.waddr == raddr) &&
           (tuse != TUSE_NONE) && (tuse < x.tnew);
  endfunction

  // Producer x holds a finished result for register target
  function automatic logic fwd_ready(input stage_rec_t x,
                                     input logic [AW-1:0] target);
    return (x.waddr != '0) && (x.tnew == '0) && (x.waddr == target);
  endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// Purpose: one pipeline record register (E, M or W) with optional bubble and Tnew ageing.
// Latency: 1 cycle input to output.
// Backpressure: none; bubble loads an all-zero record (no write, tnew 0).
// Ports: clk, reset_n (async active-low), bubble, rec_i (incoming record), rec_o (registered record).
module hazard_stage_rec
  import hazard_ctrl_pkg::*;
#(
  parameter bit AGE_TNEW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bubble,
  input  stage_rec_t rec_i,
  output stage_rec_t rec_o
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  always_comb begin
    rec_d = rec_i;
    if (AGE_TNEW) begin
      rec_d.tnew = tnew_age(rec_i.tnew);
    end
    if (bubble) begin
      rec_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall/forward controller driven by the D-stage Tuse/Tnew descriptor.
// Latency: stall and forward selects are combinational; records advance one stage per cycle.
// Backpressure: stall freezes PC/IF-ID and injects a bubble into E; no other enable.
// Ports: clk, reset_n (async active-low); d_raddr0/1, d_tuse0/1, d_waddr, d_tnew (D descriptor);
//        stall; fwd_d_rs/rt, fwd_e_rs/rt (0=GRF/ID-EX,1=E,2=M,3=W); fwd_m_rt (0=EX-MEM,1=W).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] d_raddr0,
  input  logic [AW-1:0] d_raddr1,
  input  logic [TW-1:0] d_tuse0,
  input  logic [TW-1:0] d_tuse1,
  input  logic [AW-1:0] d_waddr,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic          fwd_m_rt
);

  stage_rec_t d_rec;
  stage_rec_t e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;

  assign d_rec = '{raddr0: d_raddr0, raddr1: d_raddr1, waddr: d_waddr, tnew: d_tnew};

  // E takes d_tnew as-is: Tnew is counted from E entry, ageing starts at E->M.
  hazard_stage_rec #(.AGE_TNEW(1'b0)) u_e (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  (stall),
    .rec_i   (d_rec),
    .rec_o   (e_rec)
  );

  hazard_stage_rec #(.AGE_TNEW(1'b1)) u_m (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  (1'b0),
    .rec_i   (e_rec),
    .rec_o   (m_rec)
  );

  hazard_stage_rec #(.AGE_TNEW(1'b1)) u_w (
    .clk     (clk),
    .reset_n (reset_n),
    .bubble  (1'b0),
    .rec_i   (m_rec),
    .rec_o   (w_rec)
  );

  // W is only a forwarding source; M's rs is never forwarded into.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{w_rec.raddr0, w_rec.raddr1, m_rec.raddr0};

  // W never stalls: its tnew is always 0 by construction of the pipeline depth.
  always_comb begin
    stall = stall_hit(e_rec, d_raddr0, d_tuse0) ||
            stall_hit(e_rec, d_raddr1, d_tuse1) ||
            stall_hit(m_rec, d_raddr0, d_tuse0) ||
            stall_hit(m_rec, d_raddr1, d_tuse1);
  end

  // Youngest ready producer wins.
  always_comb begin
    fwd_d_rs = FWD_GRF;
    if (fwd_ready(e_rec, d_raddr0))      fwd_d_rs = FWD_E;
    else if (fwd_ready(m_rec, d_raddr0)) fwd_d_rs = FWD_M;
    else if (fwd_ready(w_rec, d_raddr0)) fwd_d_rs = FWD_W;

    fwd_d_rt = FWD_GRF;
    if (fwd_ready(e_rec, d_raddr1))      fwd_d_rt = FWD_E;
    else if (fwd_ready(m_rec, d_raddr1)) fwd_d_rt = FWD_M;
    else if (fwd_ready(w_rec, d_raddr1)) fwd_d_rt = FWD_W;
  end

  always_comb begin
    fwd_e_rs = FWD_GRF;
    if (fwd_ready(m_rec, e_rec.raddr0))      fwd_e_rs = FWD_M;
    else if (fwd_ready(w_rec, e_rec.raddr0)) fwd_e_rs = FWD_W;

    fwd_e_rt = FWD_GRF;
    if (fwd_ready(m_rec, e_rec.raddr1))      fwd_e_rt = FWD_M;
    else if (fwd_ready(w_rec, e_rec.raddr1)) fwd_e_rt = FWD_W;

    fwd_m_rt = fwd_ready(w_rec, m_rec.raddr1);
  end

endmodule
